// File: rtl/m6809_romsel_latch.sv
// CPU-writable ROM slot select with deferred switching and a settle window.
// Optional feature: define ROMSEL_LOCK_EN for a sticky write lock in SEL bit 7.
module m6809_romsel_latch #(
  parameter logic [15:0] IO_BASE       = 16'hFE40,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          CNT_W         = 3
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] adr,
  input  logic        rnw,
  input  logic        bus_valid,
  input  logic [7:0]  data_in,
  input  logic [2:0]  dip,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [2:0]  rom_sel,
  output logic        sel_stable,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  function automatic logic [2:0] map_slot(input logic [2:0] v);
    return (v > 3'd5) ? 3'd0 : v;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       rom_sel_q, rom_sel_d;
  logic [2:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  logic       wr_sel, wr_ok, rd, commit_ok, lock, unused_bits;
  logic [2:0] wr_val;

  assign wr_sel    = bus_valid & ~rnw & (adr == IO_BASE);
  assign rd        = bus_valid & rnw & (adr[15:1] == IO_BASE[15:1]);
  assign commit_ok = bus_valid & (adr[15:14] != 2'b11);
  assign wr_ok     = wr_sel & ~lock;
  assign wr_val    = map_slot(data_in[2:0]);

`ifdef ROMSEL_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q | (wr_ok & data_in[7]);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  assign lock        = lock_q;
  assign unused_bits = ^data_in[6:3];
`else
  assign lock        = 1'b0;
  assign unused_bits = ^data_in[7:3];
`endif

  // With the default IO_BASE the register lives inside the ROM window, so a
  // write there never commits; only a non-ROM access moves rom_sel.
  always_comb begin
    state_d   = state_q;
    rom_sel_d = rom_sel_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          pending_d = wr_val;
          if (wr_val != rom_sel_q) state_d = PEND;
        end
      end
      PEND: begin
        if (commit_ok) begin
          rom_sel_d = pending_q;
          pulse_d   = 1'b1;
          cnt_d     = SETTLE_INIT;
          state_d   = SETTLE;
          if (wr_ok) pending_d = wr_val;
        end else if (wr_ok) begin
          pending_d = wr_val;
          if (wr_val == rom_sel_q) state_d = IDLE;
        end
      end
      SETTLE: begin
        if (wr_ok) pending_d = wr_val;
        if (cnt_q == '0) begin
          state_d = (pending_d != rom_sel_q) ? PEND : IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      rom_sel_q <= map_slot(dip);
      pending_q <= map_slot(dip);
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rom_sel_q <= rom_sel_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign rom_sel      = rom_sel_q;
  assign sel_stable   = (state_q == IDLE);
  assign switch_pulse = pulse_q;
  assign data_oe      = rd;

  always_comb begin
    data_out = 8'h00;
    if (rd) begin
      if (adr[0]) data_out = {5'b0, state_q == PEND, state_q == SETTLE, sel_stable};
      else        data_out = {lock, 4'b0, rom_sel_q};
    end
  end

endmodule

// File: tb/tb_m6809_romsel_latch.sv
// Directed, table-driven bench for m6809_romsel_latch.
// Lock checks follow ROMSEL_LOCK_EN when it is defined for the build.
module tb_m6809_romsel_latch;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] adr;
  logic        rnw;
  logic        bus_valid;
  logic [7:0]  data_in;
  logic [2:0]  dip;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [2:0]  rom_sel;
  logic        sel_stable;
  logic        switch_pulse;

  int checks   = 0;
  int failures = 0;
  int pulses;

  m6809_romsel_latch dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .adr          (adr),
    .rnw          (rnw),
    .bus_valid    (bus_valid),
    .data_in      (data_in),
    .dip          (dip),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .rom_sel      (rom_sel),
    .sel_stable   (sel_stable),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bv;
    logic        rnw;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        oe;
    logic [7:0]  dout;
    logic [2:0]  sel;
    logic        stable;
    logic        pulse;
  } vec_t;

  vec_t vecs[11];

  task automatic applyStimulus(input logic bv, input logic rw, input logic [15:0] a,
                               input logic [7:0] d);
    bus_valid = bv;
    rnw       = rw;
    adr       = a;
    data_in   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bus idle; counts sel_stable-low samples starting at the current one.
  task automatic settleCount(input string name, input int exp_low);
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00);
    while (!sel_stable && n < 20) begin
      n++;
      pulses += int'(switch_pulse);
      tick();
    end
    checkOutput(name, 16'(n), 16'(exp_low));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'hFE40, 8'h06, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'hFE40, 8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'hFE41, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'hFE40, 8'h02, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h2000, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'hFE40, 8'h05, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'hFE40, 8'h00, 1'b1, 8'h02, 3'd2, 1'b0, 1'b0};

    // Reset defaults from the DIP, including the 6/7 -> 0 fold.
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00);
    dip     = 3'd4;
    reset_b = 1'b0;
    #12;
    checkOutput("rst4 rom_sel", 16'(rom_sel), 16'd4);
    checkOutput("rst4 stable", 16'(sel_stable), 16'd1);
    checkOutput("rst4 pulse", 16'(switch_pulse), 16'd0);
    checkOutput("rst4 oe", 16'(data_oe), 16'd0);
    checkOutput("rst4 dout", 16'(data_out), 16'h00);
    reset_b = 1'b1;
    tick();
    dip     = 3'd7;
    reset_b = 1'b0;
    #1;
    checkOutput("rst7 rom_sel", 16'(rom_sel), 16'd0);
    reset_b = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].bv, vecs[i].rnw, vecs[i].adr, vecs[i].din);
      #1;
      checkOutput($sformatf("v%0d oe", i), 16'(data_oe), 16'(vecs[i].oe));
      checkOutput($sformatf("v%0d dout", i), 16'(data_out), 16'(vecs[i].dout));
      tick();
      checkOutput($sformatf("v%0d rom_sel", i), 16'(rom_sel), 16'(vecs[i].sel));
      checkOutput($sformatf("v%0d stable", i), 16'(sel_stable), 16'(vecs[i].stable));
      checkOutput($sformatf("v%0d pulse", i), 16'(switch_pulse), 16'(vecs[i].pulse));
    end

    // Pending 5 held through ROM fetches, committed by first non-ROM access.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 16'hC100 + 16'(i), 8'h00);
      tick();
      checkOutput($sformatf("romfetch%0d rom_sel", i), 16'(rom_sel), 16'd2);
      checkOutput($sformatf("romfetch%0d pulse", i), 16'(switch_pulse), 16'd0);
    end
    applyStimulus(1'b1, 1'b1, 16'hFE41, 8'h00);
    #1;
    checkOutput("pend status", 16'(data_out), 16'h04);
    tick();
    applyStimulus(1'b1, 1'b1, 16'h1000, 8'h00);
    tick();
    checkOutput("commit5 rom_sel", 16'(rom_sel), 16'd5);
    checkOutput("commit5 pulse", 16'(switch_pulse), 16'd1);
    pulses = 0;
    settleCount("commit5 settle", 4);
    checkOutput("commit5 pulse count", 16'(pulses), 16'd1);

    // Back-to-back writes while pending: last write wins, one switch.
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h03); tick(); pulses += int'(switch_pulse);
    applyStimulus(1'b1, 1'b1, 16'hC000, 8'h00); tick(); pulses += int'(switch_pulse);
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h01); tick(); pulses += int'(switch_pulse);
    applyStimulus(1'b1, 1'b1, 16'hC004, 8'h00); tick(); pulses += int'(switch_pulse);
    checkOutput("lastwin hold rom_sel", 16'(rom_sel), 16'd5);
    applyStimulus(1'b1, 1'b1, 16'h0400, 8'h00);
    tick();
    checkOutput("lastwin rom_sel", 16'(rom_sel), 16'd1);
    settleCount("lastwin settle", 4);
    checkOutput("lastwin pulse count", 16'(pulses), 16'd1);

    // Pending restored to the live value drops back to idle without a switch.
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h04); tick();
    checkOutput("restore pend stable", 16'(sel_stable), 16'd0);
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h01); tick();
    checkOutput("restore idle stable", 16'(sel_stable), 16'd1);
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h00); tick();
    checkOutput("restore pulse", 16'(switch_pulse), 16'd0);
    checkOutput("restore rom_sel", 16'(rom_sel), 16'd1);

    // Write during the settle window re-enters PEND once the window closes.
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h02); tick();
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h00); tick();
    checkOutput("settlewr commit rom_sel", 16'(rom_sel), 16'd2);
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h03); tick();
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00); tick();
    tick();
    checkOutput("settlewr hold rom_sel", 16'(rom_sel), 16'd2);
    tick();
    applyStimulus(1'b1, 1'b1, 16'hFE41, 8'h00);
    #1;
    checkOutput("settlewr status", 16'(data_out), 16'h04);
    tick();
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h00); tick();
    checkOutput("settlewr rom_sel", 16'(rom_sel), 16'd3);
    checkOutput("settlewr pulse", 16'(switch_pulse), 16'd1);
    settleCount("settlewr settle", 4);

    // Reset while a change is pending discards it.
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h05); tick();
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00);
    dip     = 3'd2;
    reset_b = 1'b0;
    #1;
    checkOutput("midrst rom_sel", 16'(rom_sel), 16'd2);
    checkOutput("midrst stable", 16'(sel_stable), 16'd1);
    #1;
    reset_b = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h00); tick();
    checkOutput("midrst pulse", 16'(switch_pulse), 16'd0);
    checkOutput("midrst after rom_sel", 16'(rom_sel), 16'd2);

    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h83); tick();
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h00); tick();
    checkOutput("w83 rom_sel", 16'(rom_sel), 16'd3);
    settleCount("w83 settle", 4);
`ifdef ROMSEL_LOCK_EN
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h01); tick();
    checkOutput("locked stable", 16'(sel_stable), 16'd1);
    applyStimulus(1'b1, 1'b1, 16'hFE40, 8'h00);
    #1;
    checkOutput("locked sel read", 16'(data_out), 16'h83);
    tick();
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00);
    dip     = 3'd4;
    reset_b = 1'b0;
    #1;
    checkOutput("unlock rom_sel", 16'(rom_sel), 16'd4);
    #1;
    reset_b = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 16'hFE40, 8'h00);
    #1;
    checkOutput("unlock sel read", 16'(data_out), 16'h04);
    tick();
`else
    applyStimulus(1'b1, 1'b1, 16'hFE40, 8'h00);
    #1;
    checkOutput("nolock sel read", 16'(data_out), 16'h03);
    tick();
    applyStimulus(1'b1, 1'b0, 16'hFE40, 8'h01); tick();
    checkOutput("nolock accept stable", 16'(sel_stable), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
